// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Independent write (AW/W/B) and read (AR/R) state machines share one register file.
module axi_lite_slave_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      wr_idx;

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // The write commits on the edge where the later of AW/W arrives, using held copies for the earlier one.
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    b_hs    = 1'b0;
    commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = !aw_held;
        WREADY  = !w_held;
        aw_hs   = AWVALID && !aw_held;
        w_hs    = WVALID && !w_held;
        commit  = (aw_held || aw_hs) && (w_held || w_hs);
        if (commit) w_next = W_RESP;
      end
      W_RESP: begin
        b_hs = BREADY;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign BVALID = (w_state == W_RESP);

  always_comb begin
    wr_addr     = aw_held ? aw_addr_q : AWADDR;
    wr_data     = w_held  ? w_data_q  : WDATA;
    wr_strb     = w_held  ? w_strb_q  : WSTRB;
    wr_in_range = addr_in_range(wr_addr);
    wr_idx      = addr_index(wr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit) BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Byte-lane merge; out-of-range writes touch nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    ar_hs   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        ar_hs   = ARVALID;
        if (ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        if (RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign RVALID = (r_state == R_DATA);

  // Sampling regs here sees the pre-write value when a commit shares this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      if (addr_in_range(ARADDR)) begin
        RDATA <= regs[addr_index(ARADDR)];
        RRESP <= RESP_OKAY;
      end else begin
        RDATA <= '0;
        RRESP <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (NUM_REGS = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Write with AW and W in the same cycle, then accept the response one cycle later.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    @(negedge clk);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check_output({tag, " bvalid"}, {31'd0, BVALID}, 32'd1);
    check_output({tag, " bresp"}, {30'd0, BRESP}, {30'd0, exp_resp});
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check_output({tag, " bvalid clr"}, {31'd0, BVALID}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    @(negedge clk);
    ARADDR = addr; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    check_output({tag, " rvalid"}, {31'd0, RVALID}, 32'd1);
    check_output({tag, " rdata"}, RDATA, exp_data);
    check_output({tag, " rresp"}, {30'd0, RRESP}, {30'd0, exp_resp});
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    check_output({tag, " rvalid clr"}, {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset awready", {31'd0, AWREADY}, 32'd1);
    check_output("reset wready", {31'd0, WREADY}, 32'd1);
    check_output("reset arready", {31'd0, ARREADY}, 32'd1);
    check_output("reset bvalid", {31'd0, BVALID}, 32'd0);
    check_output("reset rvalid", {31'd0, RVALID}, 32'd0);
    do_read("reset reg0", 32'h0, 32'h0, 2'b00);

    // Basic same-cycle write and readback
    do_write("wr 0x4", 32'h4, 32'h12345678, 4'hF, 2'b00);
    do_read("rd 0x4", 32'h4, 32'h12345678, 2'b00);

    // W arrives three cycles ahead of AW
    @(negedge clk);
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    check_output("early w wready", {31'd0, WREADY}, 32'd0);
    check_output("early w awready", {31'd0, AWREADY}, 32'd1);
    check_output("early w bvalid", {31'd0, BVALID}, 32'd0);
    repeat (2) @(negedge clk);
    check_output("early w bvalid wait", {31'd0, BVALID}, 32'd0);
    AWADDR = 32'h8; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    check_output("late aw bvalid", {31'd0, BVALID}, 32'd1);
    check_output("late aw bresp", {30'd0, BRESP}, 32'd0);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check_output("late aw wready", {31'd0, WREADY}, 32'd1);
    do_read("rd 0x8", 32'h8, 32'hCAFEF00D, 2'b00);

    // Byte strobes and the all-zero strobe
    do_write("wr 0xC", 32'hC, 32'h12345678, 4'hF, 2'b00);
    do_write("wr 0xC strb3", 32'hC, 32'hAAAAAAAA, 4'b0011, 2'b00);
    do_read("rd 0xC strb", 32'hC, 32'h1234AAAA, 2'b00);
    do_write("wr 0xC strb0", 32'hC, 32'hFFFFFFFF, 4'b0000, 2'b00);
    do_read("rd 0xC strb0", 32'hC, 32'h1234AAAA, 2'b00);
    do_write("wr 0xE strb4", 32'hE, 32'h55000000, 4'b1000, 2'b00);
    do_read("rd 0xC lane3", 32'hC, 32'h5534AAAA, 2'b00);

    // Out of range at 0x20
    do_write("wr 0x20", 32'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
    do_read("rd 0x20", 32'h20, 32'h0, 2'b10);
    do_read("oor rd 0x0", 32'h0, 32'h0, 2'b00);
    do_read("oor rd 0x4", 32'h4, 32'h12345678, 2'b00);
    do_read("oor rd 0x1C", 32'h1C, 32'h0, 2'b00);

    // Stalled write response
    @(negedge clk);
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h0000BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall bvalid", {31'd0, BVALID}, 32'd1);
      check_output("stall bresp", {30'd0, BRESP}, 32'd0);
      check_output("stall awready", {31'd0, AWREADY}, 32'd0);
      check_output("stall wready", {31'd0, WREADY}, 32'd0);
      @(negedge clk);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check_output("stall bvalid clr", {31'd0, BVALID}, 32'd0);

    // Stalled read response
    @(negedge clk);
    ARADDR = 32'h10; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall rvalid", {31'd0, RVALID}, 32'd1);
      check_output("stall rdata", RDATA, 32'h0000BEEF);
      check_output("stall rresp", {30'd0, RRESP}, 32'd0);
      check_output("stall arready", {31'd0, ARREADY}, 32'd0);
      @(negedge clk);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    check_output("stall rvalid clr", {31'd0, RVALID}, 32'd0);

    // Read and write to the same register on one edge: read sees the old value
    @(negedge clk);
    AWADDR = 32'h4; AWVALID = 1'b1; WDATA = 32'h0BADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h4; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_output("collide bvalid", {31'd0, BVALID}, 32'd1);
    check_output("collide rdata", RDATA, 32'h12345678);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0; RREADY = 1'b0;
    do_read("collide after", 32'h4, 32'h0BADBEEF, 2'b00);

    // Reset while a write response and a read response are pending
    @(negedge clk);
    AWADDR = 32'h18; AWVALID = 1'b1; WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h4; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_output("pre-rst bvalid", {31'd0, BVALID}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst bvalid", {31'd0, BVALID}, 32'd0);
    check_output("rst rvalid", {31'd0, RVALID}, 32'd0);
    check_output("rst rdata", RDATA, 32'h0);
    check_output("rst awready", {31'd0, AWREADY}, 32'd1);
    check_output("rst wready", {31'd0, WREADY}, 32'd1);
    repeat (2) @(negedge clk);
    check_output("rst no late bvalid", {31'd0, BVALID}, 32'd0);
    check_output("rst no late rvalid", {31'd0, RVALID}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      do_read("rst reg", 32'(r * 4), 32'h0, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning the number of 32-bit registers; power of two, 2..64.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; synchronous and active-high.
REQ-006 SHALL have port AWADDR  input  ADDR_WIDTH  meaning the write address.
REQ-007 SHALL have port AWVALID  input  1  meaning the write address is valid.
REQ-008 SHALL have port AWREADY  output  1  meaning the slave accepts the write address.
REQ-009 SHALL have port WDATA  input  DATA_WIDTH  meaning the write data.
REQ-010 SHALL have port WSTRB  input  DATA_WIDTH/8  meaning the byte-lane enables.
REQ-011 SHALL have port WVALID  input  1  meaning the write data is valid.
REQ-012 SHALL have port WREADY  output  1  meaning the slave accepts the write data.
REQ-013 SHALL have port BRESP  output  2  meaning the write response (00 OKAY, 10 SLVERR).
REQ-014 SHALL have port BVALID  output  1  meaning the write response is valid.
REQ-015 SHALL have port BREADY  input  1  meaning the master accepts the write response.
REQ-016 SHALL have port ARADDR  input  ADDR_WIDTH  meaning the read address.
REQ-017 SHALL have port ARVALID  input  1  meaning the read address is valid.
REQ-018 SHALL have port ARREADY  output  1  meaning the slave accepts the read address.
REQ-019 SHALL have port RDATA  output  DATA_WIDTH  meaning the read data.
REQ-020 SHALL have port RRESP  output  2  meaning the read response (00 OKAY, 10 SLVERR).
REQ-021 SHALL have port RVALID  output  1  meaning the read data is valid.
REQ-022 SHALL have port RREADY  input  1  meaning the master accepts the read data.

Function
REQ-023 SHALL treat a handshake as VALID and READY both high at a rising clk edge.
REQ-024 SHALL decode register index as addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; addr >= NUM_REGS*4 is out of range.
REQ-025 SHALL run the write FSM with states W_IDLE and W_RESP, independent of the read FSM.
REQ-026 SHALL, in W_IDLE, capture AW and W independently; AWREADY = !aw_held, WREADY = !w_held, both driven combinationally from state and held flags.
REQ-027 SHALL, at the edge where the second of AW/W is captured (or both at once), commit the write, set BVALID=1 and BRESP, and go to W_RESP; BVALID is first visible in the next cycle.
REQ-028 SHALL update only the byte lanes whose WSTRB bit is 1; WSTRB=0 SHALL return OKAY with no change.
REQ-029 SHALL, on an out-of-range write, leave all registers unchanged and return BRESP=10.
REQ-030 SHALL, in W_RESP, hold AWREADY=WREADY=0 and keep BVALID/BRESP stable until BREADY; on the B handshake, clear BVALID and the held flags and return to W_IDLE.
REQ-031 SHALL run the read FSM with states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-032 SHALL, on an AR handshake, register RDATA and RRESP, set RVALID=1 (visible the next cycle), and go to R_DATA; out-of-range reads return RDATA=0 and RRESP=10.
REQ-033 SHALL hold RDATA, RRESP and RVALID stable in R_DATA until RREADY, then clear RVALID and return to R_IDLE.
REQ-034 SHALL, when an AR handshake and a write commit to the same register share an edge, return the pre-write value.

Reset
REQ-035 SHALL, with rst high at an edge, clear all registers, BVALID, RVALID, BRESP, RRESP, RDATA and the held flags, and enter W_IDLE/R_IDLE; AWREADY=WREADY=ARREADY=1 the cycle after rst deasserts.
REQ-036 SHALL, on reset mid-transaction, drop pending responses with no late BVALID/RVALID; rst has priority over all handshakes.

Verification
REQ-037 SHALL verify: AW 0x4 and W 0x12345678 (WSTRB F) same cycle -> BVALID next cycle with BRESP=00; read 0x4 -> RDATA=0x12345678, RRESP=00.
REQ-038 SHALL verify: W sent 3 cycles before AW 0x8 -> WREADY low after W capture, commit and BVALID the cycle after the AW handshake.
REQ-039 SHALL verify: write 0xAAAAAAAA with WSTRB=0011 over 0x12345678 -> readback 0x1234AAAA.
REQ-040 SHALL verify: write and read to 0x20 with NUM_REGS=8 -> BRESP=10, no register changed; RDATA=0, RRESP=10.
REQ-041 SHALL verify: BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RRESP, RDATA stable; AWREADY/WREADY/ARREADY low throughout.
REQ-042 SHALL verify: rst asserted while BVALID=1 -> BVALID=0 next cycle, all registers read back 0.
